ps2_key_event_decoder: RTL and testbench
========================================

// Module: ps2_key_event_decoder
// PURPOSE
//  Consumes raw PS/2 set-2 scancode bytes from the PS/2 byte receiver and turns make/break
//  sequences (incl. E0/F0 prefixes) into discrete game key events. Sits between the keyboard
//  receiver and game logic; buffers events in a small FIFO and exports a held-key bitmap.
// PARAMETERS
//  FIFO_DEPTH      4        event FIFO entries; power of 2, >=2
//  TIMEOUT_CYCLES  2500000  CLK_50 cycles allowed between a prefix byte and its follow-up (50 ms)
// PORTS
//  CLK_50         in   1  50 MHz clock; the only clock
//  RESET          in   1  synchronous, active-high reset
//  SCAN_VALID     in   1  1-cycle strobe: SCAN_BYTE/SCAN_PERR valid, CLK_50 domain
//  SCAN_BYTE      in   8  received scancode byte
//  SCAN_PERR      in   1  parity/framing error on this byte
//  EVT_READY      in   1  consumer accepts head event when EVT_VALID=1
//  EVT_VALID      out  1  FIFO non-empty
//  EVT_KEY        out  3  head event key id: 0 UP,1 DOWN,2 LEFT,3 RIGHT,4 SPACE,5 ENTER
//  EVT_PRESS      out  1  1 = make (press), 0 = break (release)
//  KEY_HELD       out  6  bit[id]=1 while key held
//  FIFO_OVERFLOW  out  1  sticky; set when an event is dropped on full FIFO
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, FIFO empty, timeout counter 0. RESET wins over any input.
//  FSM states IDLE, EXT (saw E0), BRK (saw F0), EXTBRK (saw E0 F0). On SCAN_VALID:
//   IDLE: E0->EXT; F0->BRK; else decode(byte, ext=0, press=1), ->IDLE
//   EXT : F0->EXTBRK; E0->EXT (restart timer); else decode(byte, ext=1, press=1), ->IDLE
//   BRK : decode(byte, ext=0, press=0), ->IDLE      EXTBRK: decode(byte, ext=1, press=0), ->IDLE
//   BRK/EXTBRK receiving E0 or F0: sequence discarded, ->IDLE.
//  Decode map: UP=E0 75, DOWN=E0 72, LEFT=E0 6B, RIGHT=E0 74 (ext required; keypad 75/72/6B/74
//   without E0 ignored); SPACE=29 (non-ext only); ENTER=5A with or without E0. Others ignored.
//  SCAN_PERR=1 with SCAN_VALID: byte discarded, FSM->IDLE, no event.
//  Timeout: counter runs in EXT/BRK/EXTBRK, cleared on every SCAN_VALID; reaching
//   TIMEOUT_CYCLES-1 returns FSM to IDLE with no event.
//  Latency: decoded event pushed on cycle after SCAN_VALID; EVT_VALID/KEY_HELD update same edge.
//  FIFO: show-ahead; pop when EVT_VALID&&EVT_READY. Push when full drops the new event and sets
//   FIFO_OVERFLOW, unless a pop occurs same cycle (then push succeeds). Push+pop when empty:
//   not possible (push lands next edge). Pointers wrap modulo FIFO_DEPTH; extra bit for full.
//  KEY_HELD updates on every decoded event regardless of FIFO drop.
// CONFIGURATION
//  KEY_REPEAT_FILTER_EN defined: make event for a key whose KEY_HELD bit is already 1
//   (typematic repeat) is not pushed; break for a key not held is not pushed.
//  Undefined: every decoded make/break is pushed, including typematic repeats.
// STRUCTURE
//  Package ps2_key_pkg: key id constants (KEY_UP..KEY_ENTER, width 3), scancode constants
//   (SC_EXT=E0, SC_BRK=F0, SC_UP/DOWN/LEFT/RIGHT/SPACE/ENTER), FSM state encoding.
//  One sub-module: key_event_fifo (parametric FIFO_DEPTH x 4b {key,press}, show-ahead, full/empty).
//  Top holds FSM, timeout counter, decode, KEY_HELD register, overflow flag.
// TESTING
//  1 bytes E0,75 -> one event {KEY=0,PRESS=1}; KEY_HELD=6'b000001; then E0,F0,75 -> {0,0}, HELD=0
//  2 bytes 29 then F0,29 -> {4,1},{4,0}; byte 75 alone (no E0) -> no event; E0,5A -> {5,1}
//  3 EVT_READY=0, send 5 presses (UP,DOWN,LEFT,RIGHT,SPACE) -> 4 held in order, FIFO_OVERFLOW=1,
//    SPACE dropped, KEY_HELD=6'b011111; then drain -> EVT_VALID falls after 4th pop
//  4 E0 then idle TIMEOUT_CYCLES -> FSM IDLE; subsequent 75 -> no event; SCAN_PERR on 75 after E0 -> none
//  5 E0,75 x3 (typematic): with KEY_REPEAT_FILTER_EN 1 event, without 3 events
//  6 RESET asserted mid-sequence (after E0,F0) -> all outputs 0 next edge; following 75 -> no event

Source files
------------

// File: rtl/ps2_key_pkg.sv
// Shared constants for the PS/2 set-2 key event decoder: key ids, scancodes, FSM states
// and the scancode-to-key lookup.
package ps2_key_pkg;

    localparam int unsigned KEY_W    = 3;
    localparam int unsigned NUM_KEYS = 6;

    localparam logic [KEY_W-1:0] KEY_UP    = 3'd0;
    localparam logic [KEY_W-1:0] KEY_DOWN  = 3'd1;
    localparam logic [KEY_W-1:0] KEY_LEFT  = 3'd2;
    localparam logic [KEY_W-1:0] KEY_RIGHT = 3'd3;
    localparam logic [KEY_W-1:0] KEY_SPACE = 3'd4;
    localparam logic [KEY_W-1:0] KEY_ENTER = 3'd5;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} ps2_state_e;

    typedef struct packed {
        logic             hit;
        logic [KEY_W-1:0] key;
    } key_decode_t;

    // Arrow keys share codes with the keypad, so they only count behind an E0 prefix.
    function automatic key_decode_t decode_key(input logic [7:0] code, input logic ext);
        key_decode_t d;
        d.hit = 1'b0;
        d.key = KEY_UP;
        case (code)
            SC_UP:    begin d.hit = ext;  d.key = KEY_UP;    end
            SC_DOWN:  begin d.hit = ext;  d.key = KEY_DOWN;  end
            SC_LEFT:  begin d.hit = ext;  d.key = KEY_LEFT;  end
            SC_RIGHT: begin d.hit = ext;  d.key = KEY_RIGHT; end
            SC_SPACE: begin d.hit = !ext; d.key = KEY_SPACE; end
            SC_ENTER: begin d.hit = 1'b1; d.key = KEY_ENTER; end
            default:  d.hit = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ps2_key_event_decoder_if.sv
// Scancode input and key event output bundle of the PS/2 key event decoder.
// slave: decoder side; master: receiver/consumer side.
interface ps2_key_event_decoder_if import ps2_key_pkg::*; ();

    logic                SCAN_VALID;
    logic [7:0]          SCAN_BYTE;
    logic                SCAN_PERR;
    logic                EVT_READY;
    logic                EVT_VALID;
    logic [KEY_W-1:0]    EVT_KEY;
    logic                EVT_PRESS;
    logic [NUM_KEYS-1:0] KEY_HELD;
    logic                FIFO_OVERFLOW;

    modport slave (
        input  SCAN_VALID, SCAN_BYTE, SCAN_PERR, EVT_READY,
        output EVT_VALID, EVT_KEY, EVT_PRESS, KEY_HELD, FIFO_OVERFLOW
    );

    modport master (
        output SCAN_VALID, SCAN_BYTE, SCAN_PERR, EVT_READY,
        input  EVT_VALID, EVT_KEY, EVT_PRESS, KEY_HELD, FIFO_OVERFLOW
    );

endinterface

// File: rtl/ps2_key_event_decoder_fifo.sv
// key_event_fifo: show-ahead event FIFO; a push while full only lands if a pop happens
// on the same edge. Head data reads as zero while empty.
module key_event_fifo #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WIDTH      = 4
) (
    input  logic             CLK_50,
    input  logic             RESET,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             wr_en, rd_en;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge CLK_50) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

    assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 set-2 scancode to game key event decoder: prefix FSM, prefix timeout, held-key map.
// Define KEY_REPEAT_FILTER_EN to suppress typematic repeats and breaks of keys not held.
module ps2_key_event_decoder import ps2_key_pkg::*; #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
    input  logic                     CLK_50,
    input  logic                     RESET,
    ps2_key_event_decoder_if.slave   bus
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    ps2_state_e          state_q;
    logic [TW-1:0]       timer_q;
    logic [NUM_KEYS-1:0] held_q;
    logic                ovf_q;

    key_decode_t      dec;
    logic             dec_ext, dec_press, dec_hit, push_req;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [KEY_W:0]   fifo_head;

    always_comb begin
        dec_ext   = (state_q == StExt) || (state_q == StExtBrk);
        dec_press = (state_q == StIdle) || (state_q == StExt);
        dec       = decode_key(bus.SCAN_BYTE, dec_ext);
        dec_hit   = bus.SCAN_VALID && !bus.SCAN_PERR && dec.hit;
`ifdef KEY_REPEAT_FILTER_EN
        push_req  = dec_hit && (held_q[dec.key] != dec_press);
`else
        push_req  = dec_hit;
`endif
    end

    assign fifo_pop = !fifo_empty && bus.EVT_READY;

    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            state_q <= StIdle;
            timer_q <= '0;
            held_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (bus.SCAN_VALID) begin
                timer_q <= '0;
                if (bus.SCAN_PERR) begin
                    state_q <= StIdle;
                end else begin
                    unique case (state_q)
                        StIdle: begin
                            if (bus.SCAN_BYTE == SC_EXT)      state_q <= StExt;
                            else if (bus.SCAN_BYTE == SC_BRK) state_q <= StBrk;
                            else                              state_q <= StIdle;
                        end
                        StExt: begin
                            if (bus.SCAN_BYTE == SC_BRK)      state_q <= StExtBrk;
                            else if (bus.SCAN_BYTE == SC_EXT) state_q <= StExt;
                            else                              state_q <= StIdle;
                        end
                        // A second prefix after F0 is malformed; drop the whole sequence.
                        StBrk, StExtBrk: state_q <= StIdle;
                    endcase
                end
            end else if (state_q != StIdle) begin
                if (timer_q == TIMER_LAST) begin
                    state_q <= StIdle;
                    timer_q <= '0;
                end else begin
                    timer_q <= timer_q + TW'(1);
                end
            end else begin
                timer_q <= '0;
            end

            if (dec_hit) held_q[dec.key] <= dec_press;
            if (push_req && fifo_full && !fifo_pop) ovf_q <= 1'b1;
        end
    end

    key_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (KEY_W + 1)
    ) u_fifo (
        .CLK_50 (CLK_50),
        .RESET  (RESET),
        .push   (push_req),
        .pop    (fifo_pop),
        .wdata  ({dec.key, dec_press}),
        .rdata  (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign bus.EVT_VALID     = !fifo_empty;
    assign bus.EVT_KEY       = fifo_head[KEY_W:1];
    assign bus.EVT_PRESS     = fifo_head[0];
    assign bus.KEY_HELD      = held_q;
    assign bus.FIFO_OVERFLOW = ovf_q;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Bench for ps2_key_event_decoder: directed scenarios plus random scancode streams, every
// cycle compared against a prefix/queue reference model.
module tb_ps2_key_event_decoder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 16;
`ifdef KEY_REPEAT_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic CLK_50 = 1'b0;
    logic RESET  = 1'b1;
    always #10 CLK_50 = ~CLK_50;

    ps2_key_event_decoder_if bus ();

    ps2_key_event_decoder #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK_50 (CLK_50),
        .RESET  (RESET),
        .bus    (bus)
    );

    typedef struct {
        int key;
        bit press;
    } ev_t;

    ev_t      mq[$];
    bit       m_ext, m_brk;
    int       m_gap;
    bit [5:0] m_held;
    bit       m_ovf;
    int       n_checks = 0;
    int       n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Game key for a completed scancode, or -1 when the code is not one of ours.
    function automatic int key_of(input logic [7:0] b, input bit ext);
        int k;
        k = -1;
        if (ext) begin
            case (b)
                8'h75: k = 0;
                8'h72: k = 1;
                8'h6B: k = 2;
                8'h74: k = 3;
                8'h5A: k = 5;
                default: k = -1;
            endcase
        end else begin
            case (b)
                8'h29: k = 4;
                8'h5A: k = 5;
                default: k = -1;
            endcase
        end
        return k;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ext  = 0;
        m_brk  = 0;
        m_gap  = 0;
        m_held = '0;
        m_ovf  = 0;
    endtask

    task automatic model_edge(input bit v, input logic [7:0] b, input bit p, input bit r);
        bit  pop, full, push;
        int  k;
        ev_t e;
        pop  = (mq.size() > 0) && r;
        full = (mq.size() >= DEPTH);
        push = 0;
        e.key = 0;
        e.press = 0;
        if (v) begin
            m_gap = 0;
            if (p) begin
                m_ext = 0; m_brk = 0;
            end else if (b == 8'hE0) begin
                if (m_brk) begin m_ext = 0; m_brk = 0; end
                else m_ext = 1;
            end else if (b == 8'hF0) begin
                if (m_brk) begin m_ext = 0; m_brk = 0; end
                else m_brk = 1;
            end else begin
                k = key_of(b, m_ext);
                e.press = !m_brk;
                m_ext = 0; m_brk = 0;
                if (k >= 0) begin
                    e.key = k;
                    push = !FILTER || (m_held[k] != e.press);
                    m_held[k] = e.press;
                end
            end
        end else if (m_ext || m_brk) begin
            m_gap++;
            if (m_gap == TMO) begin
                m_ext = 0; m_brk = 0; m_gap = 0;
            end
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (!full || pop) mq.push_back(e);
            else m_ovf = 1;
        end
    endtask

    task automatic compare_all();
        check_eq("valid", 32'(bus.EVT_VALID), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check_eq("key", 32'(bus.EVT_KEY), 32'(mq[0].key));
            check_eq("press", 32'(bus.EVT_PRESS), 32'(mq[0].press));
        end
        check_eq("held", 32'(bus.KEY_HELD), 32'(m_held));
        check_eq("ovf", 32'(bus.FIFO_OVERFLOW), 32'(m_ovf));
    endtask

    task automatic step(input bit v, input logic [7:0] b, input bit p, input bit r);
        bus.SCAN_VALID = v;
        bus.SCAN_BYTE  = b;
        bus.SCAN_PERR  = p;
        bus.EVT_READY  = r;
        @(posedge CLK_50);
        model_edge(v, b, p, r);
        #1;
        bus.SCAN_VALID = 1'b0;
        bus.SCAN_PERR  = 1'b0;
        bus.EVT_READY  = 1'b0;
        compare_all();
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Reset is applied with a live scancode and ready present to show reset wins.
    task automatic do_reset(input string tag);
        RESET          = 1'b1;
        bus.SCAN_VALID = 1'b1;
        bus.SCAN_BYTE  = 8'h29;
        bus.SCAN_PERR  = 1'b0;
        bus.EVT_READY  = 1'b1;
        @(posedge CLK_50);
        model_reset();
        #1;
        RESET          = 1'b0;
        bus.SCAN_VALID = 1'b0;
        bus.EVT_READY  = 1'b0;
        check_eq({tag, "_valid"}, 32'(bus.EVT_VALID), 32'd0);
        check_eq({tag, "_key"}, 32'(bus.EVT_KEY), 32'd0);
        check_eq({tag, "_press"}, 32'(bus.EVT_PRESS), 32'd0);
        check_eq({tag, "_held"}, 32'(bus.KEY_HELD), 32'd0);
        check_eq({tag, "_ovf"}, 32'(bus.FIFO_OVERFLOW), 32'd0);
    endtask

    task automatic expect_pop(input string tag, input int key, input bit press);
        check_eq({tag, "_v"}, 32'(bus.EVT_VALID), 32'd1);
        check_eq({tag, "_k"}, 32'(bus.EVT_KEY), 32'(key));
        check_eq({tag, "_p"}, 32'(bus.EVT_PRESS), 32'(press));
        step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    logic [7:0] pool [8] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h5A};
    int long_gap [4];

    initial begin
        int n;
        int g;
        logic [7:0] b;
        bus.SCAN_VALID = 1'b0;
        bus.SCAN_BYTE  = 8'h00;
        bus.SCAN_PERR  = 1'b0;
        bus.EVT_READY  = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK_50);
        #1;
        do_reset("rst");

        // Extended make and break of UP
        send(8'hE0); send(8'h75);
        check_eq("t1_held", 32'(bus.KEY_HELD), 32'h01);
        expect_pop("t1_mk", 0, 1'b1);
        send(8'hE0); send(8'hF0); send(8'h75);
        check_eq("t1_held0", 32'(bus.KEY_HELD), 32'h00);
        expect_pop("t1_br", 0, 1'b0);

        // SPACE, keypad 75 ignored, extended ENTER
        send(8'h29); send(8'hF0); send(8'h29); send(8'h75); send(8'hE0); send(8'h5A);
        expect_pop("t2_sp", 4, 1'b1);
        expect_pop("t2_spb", 4, 1'b0);
        expect_pop("t2_ent", 5, 1'b1);
        check_eq("t2_empty", 32'(bus.EVT_VALID), 32'd0);

        // Overflow with consumer stalled
        do_reset("rst3");
        send(8'hE0); send(8'h75); send(8'hE0); send(8'h72);
        send(8'hE0); send(8'h6B); send(8'hE0); send(8'h74); send(8'h29);
        check_eq("t3_ovf", 32'(bus.FIFO_OVERFLOW), 32'd1);
        check_eq("t3_held", 32'(bus.KEY_HELD), 32'h1F);
        expect_pop("t3_0", 0, 1'b1);
        expect_pop("t3_1", 1, 1'b1);
        expect_pop("t3_2", 2, 1'b1);
        check_eq("t3_v3", 32'(bus.EVT_VALID), 32'd1);
        expect_pop("t3_3", 3, 1'b1);
        check_eq("t3_empty", 32'(bus.EVT_VALID), 32'd0);

        // Prefix timeout, its boundary, and parity error after a prefix
        do_reset("rst4");
        send(8'hE0); idle(TMO); send(8'h75);
        check_eq("t4_timeout", 32'(bus.EVT_VALID), 32'd0);
        send(8'hE0); idle(TMO - 1); send(8'h75);
        expect_pop("t4_edge", 0, 1'b1);
        send(8'hE0); step(1'b1, 8'h75, 1'b1, 1'b0);
        check_eq("t4_perr", 32'(bus.EVT_VALID), 32'd0);
        send(8'h75);
        check_eq("t4_after", 32'(bus.EVT_VALID), 32'd0);

        // Typematic repeat
        do_reset("rst5");
        for (int i = 0; i < 3; i++) begin send(8'hE0); send(8'h75); end
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.EVT_VALID) begin
                n++;
                step(1'b0, 8'h00, 1'b0, 1'b1);
            end
        end
        check_eq("t5_count", 32'(n), FILTER ? 32'd1 : 32'd3);

        // Reset in the middle of an extended break
        send(8'hE0); send(8'hF0);
        do_reset("t6_rst");
        send(8'h75);
        check_eq("t6_none", 32'(bus.EVT_VALID), 32'd0);

        // Random streams
        long_gap = '{TMO - 2, TMO - 1, TMO, TMO + 1};
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset("rnd_rst");
            b = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 7)];
            step(1'b1, b, $urandom_range(0, 15) == 0, $urandom_range(0, 4) < 2);
            g = ($urandom_range(0, 9) == 0) ? long_gap[$urandom_range(0, 3)]
                                            : int'($urandom_range(0, 2));
            for (int j = 0; j < g; j++) step(1'b0, 8'h00, 1'b0, $urandom_range(0, 4) < 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
